// File: rtl/sdu_pkg.sv
// Serial debug unit shared definitions.
// Receive FSM encoding, defaults and vote helper.
package sdu_pkg;
  localparam int OVS_DEF = 16;
  localparam int DATA_BITS_DEF = 8;
  localparam int SYNC_LEN_DEF = 2;

  typedef logic [1:0] rx_state_t;
  localparam rx_state_t S_IDLE  = 2'd0;
  localparam rx_state_t S_START = 2'd1;
  localparam rx_state_t S_DATA  = 2'd2;
  localparam rx_state_t S_STOP  = 2'd3;

  function automatic int mid_lo(input int ovs);
    return ovs / 2 - 1;
  endfunction

  function automatic int mid_hi(input int ovs);
    return ovs / 2 + 1;
  endfunction

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/uart_rx_sync.sv
// rxd input synchronizer.
// Resets to the idle-high level of the line.
module uart_rx_sync #(
  parameter int SYNC_LEN = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);
  logic [SYNC_LEN-1:0] ff;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ff <= '1;
    else       ff <= {ff[SYNC_LEN-2:0], d};
  end

  assign q = ff[SYNC_LEN-1];
endmodule

// File: rtl/uart_rx_16x.sv
// 8N1 UART receiver, 16x oversampled.
// Majority vote per bit, vld/rdy holding register.
module uart_rx_16x
  import sdu_pkg::*;
#(
  parameter int OVS       = OVS_DEF,
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int SYNC_LEN  = SYNC_LEN_DEF
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] d_rx,
  output logic                 vld_rx,
  input  logic                 rdy_rx,
  output logic                 frame_err,
  output logic                 overrun
);
  localparam int TW = $clog2(OVS);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] T_LO  = TW'(mid_lo(OVS));
  localparam logic [TW-1:0] T_MID = TW'(OVS / 2);
  localparam logic [TW-1:0] T_HI  = TW'(mid_hi(OVS));
  localparam logic [TW-1:0] T_END = TW'(OVS - 1);
  localparam logic [BW-1:0] B_END = BW'(DATA_BITS - 1);

  rx_state_t            state;
  rx_state_t            state_n;
  logic [TW-1:0]        tc;
  logic [BW-1:0]        bcnt;
  logic [DATA_BITS-1:0] sh;
  logic                 rs;
  logic                 s_lo;
  logic                 s_mid;
  logic                 vote;
  logic                 done;
  logic                 ferr;
  logic                 accept;

  uart_rx_sync #(.SYNC_LEN(SYNC_LEN)) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (rxd),
    .q    (rs)
  );

  assign vote   = maj3(s_lo, s_mid, rs);
  assign accept = vld_rx & rdy_rx;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:
        if (!rs) state_n = S_START;
      S_START:
        if (tc == T_HI && vote) state_n = S_IDLE;
        else if (tc == T_END)   state_n = S_DATA;
      S_DATA:
        if (tc == T_END && bcnt == B_END)
          state_n = S_STOP;
      S_STOP:
        if (tc == T_HI) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    done = 1'b0;
    ferr = 1'b0;
    if (state == S_STOP && tc == T_HI) begin
      done = vote;
      ferr = !vote;
    end
  end

  // The IDLE cycle that sees the start edge counts as tc 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tc    <= '0;
      bcnt  <= '0;
      sh    <= '0;
      s_lo  <= 1'b1;
      s_mid <= 1'b1;
    end else begin
      if (state == S_IDLE)
        tc <= rs ? '0 : TW'(1);
      else if (state_n == S_IDLE || tc == T_END)
        tc <= '0;
      else
        tc <= tc + TW'(1);
      if (tc == T_LO)  s_lo  <= rs;
      if (tc == T_MID) s_mid <= rs;
      if (state == S_START && state_n == S_DATA)
        bcnt <= '0;
      else if (state == S_DATA && tc == T_END && state_n == S_DATA)
        bcnt <= bcnt + BW'(1);
      if (state == S_DATA && tc == T_HI)
        sh <= {vote, sh[DATA_BITS-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      d_rx      <= '0;
      vld_rx    <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr;
      overrun   <= done & vld_rx & !accept;
      if (done && (!vld_rx || accept)) begin
        d_rx   <= sh;
        vld_rx <= 1'b1;
      end else if (accept) begin
        vld_rx <= 1'b0;
      end
    end
  end
endmodule
